// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core.
// Covers ALU operand forwarding, load-use stalls, flushes on redirects
// resolved in M, and the multicycle divide stall sequence.
module hazard_unit #(
    parameter int unsigned DIV_LAT = 32,  // total E-stage occupancy of a div (min 3)
    parameter int unsigned CNT_W   = 6    // must hold DIV_LAT-2
) (
    input  logic       clk,
    input  logic       rst,         // asynchronous, active-low
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       divE,
    input  logic       redirectM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       div_startE,
    output logic       div_readyE
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             div_start;
    logic             div_busy;
    logic             div_stall;
    logic             lu;

    // Divide start is qualified by redirect: a div squashed in M's shadow never starts
    always_comb begin
        div_start = (state == IDLE) && divE && !redirectM;
        div_busy  = (state == BUSY);
        div_stall = div_start || div_busy;
        lu        = memtoregE && regwriteE && (writeregE != 5'd0) &&
                    ((writeregE == rsD) || (writeregE == rtD));
    end

    // Divide sequencer: IDLE -> BUSY (DIV_LAT-2 cycles) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(DIV_LAT - 2);
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs: forwarding plus stall/flush priority (div stall > redirect > load-use).
    // Decoded from registered state and live inputs because the start pulse must
    // appear in the same cycle the div reaches E; all forced low while in reset.
    always_comb begin
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        forwardaE  = 2'b00;
        forwardbE  = 2'b00;
        div_startE = 1'b0;
        div_readyE = 1'b0;
        if (rst) begin
            if (regwriteM && (writeregM != 5'd0) && (writeregM == rsE))
                forwardaE = 2'b10;
            else if (regwriteW && (writeregW != 5'd0) && (writeregW == rsE))
                forwardaE = 2'b01;

            if (regwriteM && (writeregM != 5'd0) && (writeregM == rtE))
                forwardbE = 2'b10;
            else if (regwriteW && (writeregW != 5'd0) && (writeregW == rtE))
                forwardbE = 2'b01;

            stallF     = div_stall || (lu && !redirectM);
            stallD     = div_stall || (lu && !redirectM);
            stallE     = div_stall;
            flushD     = redirectM && !div_busy;
            flushE     = !div_stall && (redirectM || lu);
            flushM     = div_stall;
            div_startE = div_start;
            div_readyE = (state == DONE);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: DIV_LAT=4 and DIV_LAT=32 instances share
// stimulus; expected output vectors are queued per step and checked mid-cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, divE, redirectM;

    logic       sF4, sD4, sE4, fD4, fE4, fM4, st4, rd4;
    logic [1:0] fa4, fb4;
    logic       sF32, sD32, sE32, fD32, fE32, fM32, st32, rd32;
    logic [1:0] fa32, fb32;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        bit          sel;   // 0: DIV_LAT=4 instance, 1: DIV_LAT=32 instance
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_unit #(.DIV_LAT(4), .CNT_W(6)) u_dut4 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .divE(divE), .redirectM(redirectM),
        .stallF(sF4), .stallD(sD4), .stallE(sE4), .flushD(fD4), .flushE(fE4),
        .flushM(fM4), .forwardaE(fa4), .forwardbE(fb4),
        .div_startE(st4), .div_readyE(rd4)
    );

    hazard_unit #(.DIV_LAT(32), .CNT_W(6)) u_dut32 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .divE(divE), .redirectM(redirectM),
        .stallF(sF32), .stallD(sD32), .stallE(sE32), .flushD(fD32), .flushE(fE32),
        .flushM(fM32), .forwardaE(fa32), .forwardbE(fb32),
        .div_startE(st32), .div_readyE(rd32)
    );

    // {stallF,stallD,stallE,flushD,flushE,flushM,forwardaE,forwardbE,div_startE,div_readyE}
    function automatic logic [11:0] mk(input logic sF, input logic sD, input logic sE,
                                       input logic fD, input logic fE, input logic fM,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic st, input logic rd);
        return {sF, sD, sE, fD, fE, fM, fa, fb, st, rd};
    endfunction

    localparam logic [11:0] ZERO    = 12'b0;
    localparam logic [11:0] DIVSTL  = 12'b111_001_00_00_0_0;
    localparam logic [11:0] DIVSTRT = 12'b111_001_00_00_1_0;
    localparam logic [11:0] READY   = 12'b000_000_00_00_0_1;

    task automatic push(input bit sel, input string tag, input logic [11:0] e);
        exp_t x;
        x.sel = sel;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Let combinational outputs settle, then drain the scoreboard
    task automatic check();
        exp_t        x;
        logic [11:0] obs;
        #2;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = x.sel ? {sF32, sD32, sE32, fD32, fE32, fM32, fa32, fb32, st32, rd32}
                        : {sF4, sD4, sE4, fD4, fE4, fM4, fa4, fb4, st4, rd4};
            n_cmp++;
            assert (obs === x.exp)
            else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; divE = 1'b0; redirectM = 1'b0;
    endtask

    initial begin
        // Reset holds every output low, even with forwarding/div/lu conditions live
        clear_inputs();
        rst = 1'b0;
        regwriteM = 1'b1; writeregM = 5'd5; rsE = 5'd5; divE = 1'b1;
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
        #3;
        push(0, "reset_out4", ZERO);
        push(1, "reset_out32", ZERO);
        check();
        clear_inputs();
        rst = 1'b1;
        next();
        push(0, "idle_after_reset4", ZERO);
        push(1, "idle_after_reset32", ZERO);
        check();

        // Forwarding: M beats W, W used when M doesn't write, $0 never forwarded
        writeregM = 5'd5; writeregW = 5'd5; regwriteM = 1'b1; regwriteW = 1'b1;
        rsE = 5'd5; rtE = 5'd0;
        push(0, "fwd_m_priority", mk(0,0,0,0,0,0,2'b10,2'b00,0,0));
        check();
        next();
        regwriteM = 1'b0;
        push(0, "fwd_w", mk(0,0,0,0,0,0,2'b01,2'b00,0,0));
        check();
        next();
        writeregW = 5'd0; rsE = 5'd0;
        push(0, "fwd_w_zero", ZERO);
        check();
        next();
        regwriteM = 1'b1; writeregM = 5'd0; rtE = 5'd0;
        push(0, "fwd_m_zero", ZERO);
        check();
        next();
        writeregM = 5'd9; writeregW = 5'd9; regwriteW = 1'b1; rtE = 5'd9; rsE = 5'd3;
        push(0, "fwd_b_m", mk(0,0,0,0,0,0,2'b00,2'b10,0,0));
        check();
        next();
        regwriteM = 1'b0; rsE = 5'd9;
        push(0, "fwd_ab_w", mk(0,0,0,0,0,0,2'b01,2'b01,0,0));
        check();
        next();
        clear_inputs();

        // Load-use on rt, then on rs, then the bubble cycle, then $0 destination
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
        push(0, "lu_rt", mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
        check();
        next();
        memtoregE = 1'b0; regwriteE = 1'b0; writeregE = 5'd0;
        push(0, "lu_one_cycle", ZERO);
        check();
        next();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd12; rsD = 5'd12; rtD = 5'd1;
        push(0, "lu_rs", mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
        check();
        next();
        writeregE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        push(0, "lu_reg0", ZERO);
        check();
        next();

        // Redirect overrides load-use
        writeregE = 5'd8; rtD = 5'd8; redirectM = 1'b1;
        push(0, "redirect_vs_lu", mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
        check();
        next();
        clear_inputs();
        push(0, "after_redirect", ZERO);
        check();

        // Divide, DIV_LAT=4: start at t, stalls t..t+2, ready t+3, idle t+4
        next();
        divE = 1'b1;
        push(0, "div_t", DIVSTRT);
        check();
        next();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd7; rsD = 5'd7;
        push(0, "div_t1_lu_no_flushE", DIVSTL);
        check();
        next();
        clear_inputs(); divE = 1'b1; redirectM = 1'b1;
        push(0, "div_t2_redirect_ignored", DIVSTL);
        check();
        next();
        redirectM = 1'b0;
        push(0, "div_t3_ready", READY);
        check();
        next();
        divE = 1'b0;
        push(0, "div_t4_idle", ZERO);
        check();
        next();

        // Div squashed by a redirect in the same cycle
        divE = 1'b1; redirectM = 1'b1;
        push(0, "div_squash", mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
        check();
        next();
        divE = 1'b0; redirectM = 1'b0;
        push(0, "div_squash_idle", ZERO);
        check();
        next();
        divE = 1'b1;
        push(0, "div_after_squash_start", DIVSTRT);
        check();
        divE = 1'b0;

        // Reset mid-divide on the DIV_LAT=32 instance
        rst = 1'b0;
        #2;
        rst = 1'b1;
        next();
        divE = 1'b1;
        push(1, "d32_t", DIVSTRT);
        check();
        next();
        push(1, "d32_t1", DIVSTL);
        check();
        rst = 1'b0;
        push(1, "d32_reset_mid", ZERO);
        push(0, "d4_reset_mid", ZERO);
        check();
        divE = 1'b0;
        rst = 1'b1;
        next();
        push(1, "d32_after_release", ZERO);
        check();
        next();
        divE = 1'b1;
        for (int i = 0; i < 31; i++) begin
            push(1, $sformatf("d32_stall_%0d", i), (i == 0) ? DIVSTRT : DIVSTL);
            check();
            next();
        end
        push(1, "d32_ready", READY);
        check();
        next();
        divE = 1'b0;
        push(1, "d32_idle", ZERO);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Sits beside the main decoder/controller. Produces its stallD/stallE/flushD/flushE/flushM inputs and the datapath's PC-stall and ALU-operand forwarding selects.
- Handles three things:
  - load-use stalls;
  - flushes on control-flow redirects resolved in M (branches and all jumps);
  - a multicycle divide stall sequenced by an internal FSM/counter.
- stallM, stallW and flushW are tied 0 at top level and are not generated here.

Parameters:
DIV_LAT, 32, total E-stage occupancy of a div/divu in cycles (min 3)
CNT_W, 6, width of the divide counter (must hold DIV_LAT-2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rsD  in  5  source reg rs of instruction in D
rtD  in  5  source reg rt of instruction in D
rsE  in  5  source reg rs of instruction in E
rtE  in  5  source reg rt of instruction in E
writeregE  in  5  destination reg of instruction in E
writeregM  in  5  destination reg of instruction in M
writeregW  in  5  destination reg of instruction in W
regwriteE  in  1  E instruction writes a register
regwriteM  in  1  M instruction writes a register
regwriteW  in  1  W instruction writes a register
memtoregE  in  1  E instruction is a load
divE  in  1  E instruction is div/divu
redirectM  in  1  pcsrcM | jumpM | jrM | jalM | jalrM | balM
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
stallE  out  1  hold ID/EX register
flushD  out  1  clear IF/ID register
flushE  out  1  clear ID/EX register
flushM  out  1  clear EX/MEM register (bubble)
forwardaE  out  2  ALU A select: 00 regfile, 01 W result, 10 M ALU result
forwardbE  out  2  ALU B select, same encoding
div_startE  out  1  one-cycle start pulse to the divider
div_readyE  out  1  divider result valid; E may advance

Behaviour:
- Forwarding (combinational):
  - forwardaE = 10 if regwriteM & writeregM!=0 & writeregM==rsE.
  - Else forwardaE = 01 if regwriteW & writeregW!=0 & writeregW==rsE.
  - Else forwardaE = 00.
  - forwardbE uses the same rules with rtE. M has priority over W. Register $0 is never forwarded.
- Load-use (lu) = memtoregE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
  - Effect: stallF=stallD=1 and flushE=1, inserting one bubble.
- Redirect, when redirectM=1:
  - flushD=1 and flushE=1, squashing the two younger instructions.
  - stallF=0 so the redirected PC loads.
  - Overrides lu.
  - Suppresses a div start in the same cycle, because the div in E is squashed.
- Divide FSM, states IDLE, BUSY, DONE, with counter cnt[CNT_W-1:0]:
  - IDLE & divE & !redirectM:
    - div_startE=1; stallF=stallD=stallE=1; flushM=1.
    - Next state BUSY with cnt=DIV_LAT-2.
  - BUSY:
    - stallF=stallD=stallE=1; flushM=1.
    - cnt decrements each cycle. When cnt==1, next state is DONE.
  - DONE:
    - div_readyE=1; no div stall. The div advances at the next edge.
    - Next state IDLE unconditionally; divE still high in DONE does not restart.
  - Net effect: DIV_LAT-1 stall cycles, and the div leaves E exactly DIV_LAT cycles after entering it.
- Simultaneous events:
  - During BUSY the instruction in M is a bubble, so redirectM=0 by construction. If redirectM is asserted anyway, the FSM ignores it and flushes stay as for BUSY.
  - lu during BUSY/IDLE-start: the div stall already covers D; flushE is NOT asserted, because E holds the div. The div stall wins over lu.
  - After DONE, a pending lu is re-evaluated normally.
- Reset:
  - Asynchronous, rst=0: FSM goes to IDLE and cnt=0, including mid-BUSY.
  - While rst=0, all outputs are 0 (forward selects 00).
  - After release, the first divE starts a full sequence.

Test Plan:
- Forward priority: writeregM=writeregW=5, regwriteM=regwriteW=1, rsE=5, rtE=0 -> forwardaE=10, forwardbE=00. Then regwriteM=0 -> forwardaE=01. Then writeregW=0 with rsE=0 -> forwardaE=00.
- Load-use: memtoregE=regwriteE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1 for exactly one cycle. With writeregE=0 -> no stall.
- Redirect vs lu: lu condition true plus redirectM=1 -> flushD=flushE=1, stallF=stallD=0.
- Divide, DIV_LAT=4: divE rises at cycle t:
  - div_startE=1 at t only.
  - stallE=flushM=1 at t, t+1, t+2.
  - div_readyE=1 at t+3 with stalls 0.
  - FSM IDLE at t+4; no restart while divE stays high at t+3.
- Div squashed: divE=1 and redirectM=1 together -> div_startE=0, FSM stays IDLE, flushE=1.
- Reset mid-divide: assert rst=0 at t+1 of a DIV_LAT=32 sequence -> all outputs 0 immediately. After release with divE=0, FSM is IDLE and no stalls; a new divE gives 31 stall cycles.
